// File: rtl/eab_mem_sequencer_if.sv
// Memory handshake bundle between the sequencer and the memory port.
interface eab_mem_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/eab_mem_sequencer.sv
// Multi-cycle sequencer for LC-3 memory instructions (LD/ST/LDI/STI/LDR/STR/LEA).
// Strobes are decoded from the state register; only ldMDR during a read is
// qualified by mem_ready in the same cycle.
module eab_mem_sequencer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  opcode,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        selEAB1,
  output logic [1:0]  selEAB2,
  output logic        ldMAR,
  output logic        selMAR,
  output logic        ldMDR,
  output logic        ldReg,
  output logic        selRegSrc,
  output logic        ldCC,
  eab_mem_sequencer_if.master mem
);

  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef enum logic [3:0] {IDLE, ADDR, RD1, IND, RD2, STD, WR, WB, FIN} state_t;

  state_t           state, nxt;
  logic [3:0]       op;
  logic             err_q, to_err;
  logic [CNT_W-1:0] cnt;
  logic             legal, pc_rel, timeout_hit, req_state;

  // PC-relative forms use the 9-bit offset; base+offset forms use Ra + 6-bit offset.
  assign pc_rel = (opcode == OP_LD) || (opcode == OP_ST) || (opcode == OP_LDI) ||
                  (opcode == OP_STI) || (opcode == OP_LEA);
  assign legal  = pc_rel || (opcode == OP_LDR) || (opcode == OP_STR);

  // Last permitted request cycle without ready: the next one would exceed TIMEOUT.
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign req_state   = (state == RD1) || (state == RD2) || (state == WR);

  // Next-state and strobe decode.
  always_comb begin
    nxt           = state;
    to_err        = 1'b0;
    ldMAR         = 1'b0;
    selMAR        = 1'b0;
    ldMDR         = 1'b0;
    ldReg         = 1'b0;
    selRegSrc     = 1'b0;
    ldCC          = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    busy          = (state != IDLE);
    done          = (state == FIN);
    err           = (state == FIN) && err_q;
    case (state)
      IDLE: if (start) begin
        if (opcode == OP_LEA) nxt = WB;
        else if (legal)       nxt = ADDR;
        else begin
          nxt    = FIN;
          to_err = 1'b1;
        end
      end
      ADDR: begin
        ldMAR = 1'b1;
        nxt   = ((op == OP_ST) || (op == OP_STR)) ? STD : RD1;
      end
      RD1, RD2: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          ldMDR = 1'b1;
          nxt   = ((state == RD1) && ((op == OP_LDI) || (op == OP_STI))) ? IND : WB;
        end else if (timeout_hit) begin
          nxt    = FIN;
          to_err = 1'b1;
        end
      end
      IND: begin
        ldMAR  = 1'b1;
        selMAR = 1'b1;
        nxt    = (op == OP_STI) ? STD : RD2;
      end
      STD: begin
        ldMDR = 1'b1;
        nxt   = WR;
      end
      WR: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        if (mem.mem_ready) nxt = FIN;
        else if (timeout_hit) begin
          nxt    = FIN;
          to_err = 1'b1;
        end
      end
      WB: begin
        ldReg     = 1'b1;
        ldCC      = 1'b1;
        selRegSrc = (op != OP_LEA);
        nxt       = FIN;
      end
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State, latched opcode/address selects, error flag and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op      <= 4'b0000;
      selEAB1 <= 1'b0;
      selEAB2 <= 2'b00;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= nxt;
      if ((state == IDLE) && start) begin
        op      <= opcode;
        selEAB1 <= legal && !pc_rel;
        selEAB2 <= !legal ? 2'b00 : (pc_rel ? 2'b10 : 2'b01);
      end
      if ((state != FIN) && (nxt == FIN)) err_q <= to_err;
      // Counter only runs while a request waits; any other state clears it,
      // so every request window starts from zero.
      if (req_state && !mem.mem_ready) cnt <= cnt + 1'b1;
      else                             cnt <= '0;
    end
  end

endmodule

// File: tb/tb_eab_mem_sequencer.sv
// Directed bench for eab_mem_sequencer (TIMEOUT=4).
module tb_eab_mem_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [3:0] opcode = 4'b0000;
  logic busy, done, err, selEAB1, ldMAR, selMAR, ldMDR, ldReg, selRegSrc, ldCC;
  logic [1:0] selEAB2;
  int total = 0;
  int bad = 0;

  eab_mem_sequencer_if bus();

  eab_mem_sequencer #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .busy(busy), .done(done),
    .err(err), .selEAB1(selEAB1), .selEAB2(selEAB2), .ldMAR(ldMAR), .selMAR(selMAR),
    .ldMDR(ldMDR), .ldReg(ldReg), .selRegSrc(selRegSrc), .ldCC(ldCC), .mem(bus.master)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] OP_LD = 4'b0010, OP_LDI = 4'b1010, OP_STI = 4'b1011;
  localparam logic [3:0] OP_STR = 4'b0111, OP_LEA = 4'b1110;

  // Per-cycle record, index = cycles after the start edge.
  logic r_ldmar [0:20], r_selmar [0:20], r_ldmdr [0:20], r_req [0:20], r_we [0:20];
  logic r_ldreg [0:20], r_src [0:20], r_ldcc [0:20], r_done [0:20], r_err [0:20];
  logic r_busy [0:20], r_sel1 [0:20];
  logic [1:0] r_sel2 [0:20];

  task automatic go(input logic [3:0] op);
    @(negedge clk);
    start = 1'b1;
    opcode = op;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Memory answers on the (dly+1)-th cycle of each request window.
  task automatic capture(input int n, input int dly);
    int w;
    w = 0;
    for (int k = 1; k <= n; k++) begin
      if (bus.mem_req) begin
        bus.mem_ready = (w >= dly);
        w++;
      end else begin
        bus.mem_ready = 1'b0;
        w = 0;
      end
      #1;
      r_ldmar[k] = ldMAR; r_selmar[k] = selMAR; r_ldmdr[k] = ldMDR;
      r_req[k] = bus.mem_req; r_we[k] = bus.mem_we; r_ldreg[k] = ldReg;
      r_src[k] = selRegSrc; r_ldcc[k] = ldCC; r_done[k] = done; r_err[k] = err;
      r_busy[k] = busy; r_sel1[k] = selEAB1; r_sel2[k] = selEAB2;
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, err, ldMAR, selMAR, ldMDR, bus.mem_req, bus.mem_we, ldReg, selRegSrc, ldCC,
         selEAB1, selEAB2} !== 14'b0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b req=%0b sel=%0b/%0b want all 0",
               busy, done, bus.mem_req, selEAB1, selEAB2);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ld();
    go(OP_LD);
    capture(5, 0);
    total++;
    if ({r_ldmar[1], r_selmar[1], r_req[1], r_busy[1]} !== 4'b1001) begin
      bad++; $display("FAIL ld_addr: got ldMAR=%0b selMAR=%0b req=%0b busy=%0b want 1 0 0 1",
                      r_ldmar[1], r_selmar[1], r_req[1], r_busy[1]);
    end
    total++;
    if ({r_req[2], r_we[2], r_ldmdr[2]} !== 3'b101) begin
      bad++; $display("FAIL ld_rd1: got req=%0b we=%0b ldMDR=%0b want 1 0 1", r_req[2], r_we[2], r_ldmdr[2]);
    end
    total++;
    if ({r_ldreg[3], r_ldcc[3], r_src[3]} !== 3'b111) begin
      bad++; $display("FAIL ld_wb: got ldReg=%0b ldCC=%0b src=%0b want 1 1 1", r_ldreg[3], r_ldcc[3], r_src[3]);
    end
    total++;
    if ({r_done[3], r_done[4], r_err[4], r_busy[4], r_busy[5], r_done[5]} !== 6'b010100) begin
      bad++; $display("FAIL ld_done: got done3=%0b done4=%0b err4=%0b busy4=%0b busy5=%0b want done@4 only",
                      r_done[3], r_done[4], r_err[4], r_busy[4], r_busy[5]);
    end
    total++;
    if ({r_sel1[2], r_sel2[2]} !== 3'b010) begin
      bad++; $display("FAIL ld_sel: got %0b/%0b want 0/10", r_sel1[2], r_sel2[2]);
    end
  endtask

  task automatic test_ldi();
    int nreq, nreg, dat, nmdr;
    nreq = 0; nreg = 0; dat = 0; nmdr = 0;
    go(OP_LDI);
    capture(13, 3);
    for (int k = 1; k <= 13; k++) begin
      if (r_req[k]) nreq++;
      if (r_ldreg[k]) nreg++;
      if (r_ldmdr[k]) nmdr++;
      if (r_done[k] && dat == 0) dat = k;
    end
    total++;
    if (nreq !== 8 || r_req[5] !== 1'b1 || r_req[6] !== 1'b0 || r_req[7] !== 1'b1 || r_req[10] !== 1'b1) begin
      bad++; $display("FAIL ldi_req_windows: got %0d req cycles want 8 in cycles 2-5,7-10", nreq);
    end
    total++;
    if ({r_ldmar[6], r_selmar[6], r_selmar[1], r_ldmdr[5], r_ldmdr[10]} !== 5'b11011 || nmdr !== 2) begin
      bad++; $display("FAIL ldi_ind: got ldMAR6=%0b selMAR6=%0b ldMDR count=%0d want 1 1 2",
                      r_ldmar[6], r_selmar[6], nmdr);
    end
    total++;
    if (dat !== 12 || nreg !== 1 || r_ldreg[11] !== 1'b1) begin
      bad++; $display("FAIL ldi_done: got done@%0d ldReg count=%0d want done@12 count=1", dat, nreg);
    end
  endtask

  task automatic test_str();
    int nreg;
    nreg = 0;
    go(OP_STR);
    capture(5, 0);
    for (int k = 1; k <= 5; k++) if (r_ldreg[k]) nreg++;
    total++;
    if ({r_sel1[1], r_sel2[1]} !== 3'b101) begin
      bad++; $display("FAIL str_sel: got %0b/%0b want 1/01", r_sel1[1], r_sel2[1]);
    end
    total++;
    if ({r_ldmdr[2], r_req[2], r_req[3], r_we[3]} !== 4'b1011) begin
      bad++; $display("FAIL str_std_wr: got ldMDR2=%0b req2=%0b req3=%0b we3=%0b want 1 0 1 1",
                      r_ldmdr[2], r_req[2], r_req[3], r_we[3]);
    end
    total++;
    if (r_done[4] !== 1'b1 || r_err[4] !== 1'b0 || nreg !== 0) begin
      bad++; $display("FAIL str_done: got done4=%0b err4=%0b ldReg count=%0d want 1 0 0", r_done[4], r_err[4], nreg);
    end
  endtask

  task automatic test_sti();
    go(OP_STI);
    capture(7, 0);
    total++;
    if ({r_req[2], r_selmar[3], r_ldmdr[4], r_req[5], r_we[5], r_done[5], r_done[6]} !== 7'b1111101) begin
      bad++; $display("FAIL sti_seq: got req2=%0b selMAR3=%0b ldMDR4=%0b we5=%0b done6=%0b want 1 1 1 1 1",
                      r_req[2], r_selmar[3], r_ldmdr[4], r_we[5], r_done[6]);
    end
  endtask

  task automatic test_lea();
    int nreq;
    nreq = 0;
    go(OP_LEA);
    capture(3, 0);
    for (int k = 1; k <= 3; k++) if (r_req[k]) nreq++;
    total++;
    if ({r_ldreg[1], r_ldcc[1], r_src[1], r_done[2], r_err[2]} !== 5'b11010 || nreq !== 0) begin
      bad++; $display("FAIL lea: got ldReg=%0b src=%0b done2=%0b req count=%0d want 1 0 1 0",
                      r_ldreg[1], r_src[1], r_done[2], nreq);
    end
  endtask

  task automatic test_timeout();
    int nreq, nreg;
    nreq = 0; nreg = 0;
    go(OP_LD);
    capture(7, 99);
    for (int k = 1; k <= 7; k++) begin
      if (r_req[k]) nreq++;
      if (r_ldreg[k]) nreg++;
    end
    total++;
    if (nreq !== 4 || r_req[5] !== 1'b1 || r_req[6] !== 1'b0) begin
      bad++; $display("FAIL timeout_req: got %0d req cycles want 4 (cycles 2-5)", nreq);
    end
    total++;
    if (r_done[6] !== 1'b1 || r_err[6] !== 1'b1 || nreg !== 0) begin
      bad++; $display("FAIL timeout_err: got done6=%0b err6=%0b ldReg count=%0d want 1 1 0", r_done[6], r_err[6], nreg);
    end
  endtask

  task automatic test_illegal();
    go(4'b0001);
    capture(2, 0);
    total++;
    if ({r_done[1], r_err[1], r_busy[1], r_busy[2], r_ldmar[1]} !== 5'b11100) begin
      bad++; $display("FAIL illegal: got done=%0b err=%0b busy1=%0b busy2=%0b want 1 1 1 0",
                      r_done[1], r_err[1], r_busy[1], r_busy[2]);
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    nd = 0;
    go(OP_LDI);
    capture(5, 1);      // ADDR@1, RD1@2-3, IND@4, RD2 from 5 on
    total++;
    if (bus.mem_req !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL rst_mid_in_rd2: got req=%0b busy=%0b want 1 1", bus.mem_req, busy);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({busy, done, err, bus.mem_req, ldMDR, ldReg, selEAB1, selEAB2} !== 9'b0) begin
      bad++; $display("FAIL rst_mid_outputs: got busy=%0b done=%0b req=%0b sel2=%0b want 0",
                      busy, done, bus.mem_req, selEAB2);
    end
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1 if (done) nd++;
    end
    total++;
    if (nd !== 0) begin
      bad++; $display("FAIL rst_mid_no_done: got %0d done pulses want 0", nd);
    end
  endtask

  task automatic test_start_busy();
    int nd, at;
    nd = 0; at = 0;
    bus.mem_ready = 1'b1;
    go(OP_LD);
    start = 1'b1;
    opcode = OP_LEA;
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (done) begin nd++; at = k; end
      @(negedge clk) start = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b0;
    total++;
    if (nd !== 1 || at !== 4) begin
      bad++; $display("FAIL start_busy: got %0d done pulses last@%0d want 1 @4", nd, at);
    end
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    test_reset();
    test_ld();
    test_ldi();
    test_str();
    test_sti();
    test_lea();
    test_timeout();
    test_illegal();
    test_reset_mid();
    test_start_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
